down_counter8: RTL and testbench
================================

Name: down_counter8

Overview:
Loadable 3-bit countdown counter, the down-counting counterpart of the team's 3-bit up counter. Counts from a loaded value to 0 at a programmable tick rate and stops at 0 without wrapping. Supports start, pause and resume, and raises a done flag at 0. Drives the existing display7 seven-segment decoder, so the board shows the current count.

Parameters:
WIDTH, 3, counter width in bits; the display path requires WIDTH <= 4.
TICK_DIV, 1, CLK cycles per count step; must be >= 1; 1 = step every cycle.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
iLoad  input  1  load iData into the counter; highest priority after rst.
iData  input  WIDTH  load value.
iStart  input  1  start from IDLE, or resume from PAUSE.
iPause  input  1  pause while in RUN.
oQ  output  WIDTH  current count, registered.
oDone  output  1  high while in DONE, registered.
oBusy  output  1  high in RUN or PAUSE.
oDisplay  output  7  segment pattern for {1'b0, oQ} from display7; polarity is whatever display7 produces.

Behaviour:
- One clock and one reset: CLK drives every register; rst is synchronous and active-high.
- Reset, regardless of other inputs: state=IDLE, oQ=0, oDone=0, oBusy=0, prescaler=0. rst mid-count aborts immediately; values hold from the next edge.
- States are IDLE, RUN, PAUSE, DONE. Input priority each edge: rst > iLoad > iPause > iStart > tick.
- iLoad in any state: oQ<=iData; state<=IDLE; prescaler<=0; oDone<=0. A simultaneous iStart is ignored.
- IDLE:
  - iStart with oQ!=0 -> RUN, prescaler<=0.
  - iStart with oQ==0 -> DONE.
  - Otherwise hold.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - Tick = (prescaler==TICK_DIV-1). On a tick the prescaler wraps to 0 and oQ<=oQ-1.
  - A tick with oQ==1 gives oQ=0 and moves to DONE on the same edge, so oDone is high in the same cycle oQ first reads 0.
  - iPause -> PAUSE: the tick in that cycle is suppressed and the prescaler holds its value.
- PAUSE: oQ and prescaler frozen. iStart -> RUN and the prescaler continues from its held value. iPause has no further effect.
- DONE: oQ held at 0, oDone=1. iStart and iPause are ignored; only iLoad or rst leaves DONE.
- Latency: iStart sampled at edge k puts the block in RUN after edge k; the first decrement happens at edge k+TICK_DIV.
- No wrap-around: oQ never goes from 0 to 2^WIDTH-1.
- oBusy is decoded from the state register and is glitch-free.
- oDisplay is combinational from oQ through display7.

Decomposition:
- Shared include file: state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and a TICK_DIV-based prescaler width macro.
- One natural sub-module: tick_gen, a prescaler with clear, hold and tick outputs.
- display7 is instantiated unchanged.

Test Plan:
1. Reset: hold rst for 2 cycles with iLoad=1, iData=5 -> oQ=0, oDone=0, oBusy=0, state IDLE; oDisplay equals display7's pattern for 0.
2. Full count, TICK_DIV=1: iLoad with iData=5, then iStart -> oQ reads 4,3,2,1,0 on consecutive edges; oDone=1 on the edge oQ becomes 0; oQ stays 0 for 10 more cycles with iStart pulsed (no wrap to 7).
3. Pause and resume: load 7, start, assert iPause once oQ=5 -> oQ stays 5 for 3 cycles with oBusy=1; then iStart -> 4,3,... resumes.
4. Zero load: load 0, then iStart -> DONE after one edge, oQ=0, oDone=1, oBusy=0.
5. Priority: in RUN at oQ=4, assert iLoad with iData=3 together with iPause and iStart -> next edge oQ=3, IDLE, oDone=0, oBusy=0.
6. TICK_DIV=4: load 2, start at edge k -> oQ=1 at edge k+4, oQ=0 with oDone=1 at edge k+8. Rerun and assert rst at edge k+5 -> oQ=0, IDLE from the next edge.

Source files
------------

// File: rtl/down_counter8_pkg.sv
// Shared definitions for the down_counter8 slice: state encoding and prescaler sizing.
package down_counter8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Prescaler register width for a given divide ratio; always at least one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/display7.sv
// Hex-to-seven-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module display7 (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (value)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/down_counter8_tick_gen.sv
// Prescaler counting 0..TICK_DIV-1 while enabled; holds otherwise, clear has priority.
module down_counter8_tick_gen
  import down_counter8_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Terminal count, ungated; the owner decides whether it counts as a step.
  assign tick_c = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/down_counter8.sv
// Loadable countdown counter with start/pause/resume, stop-at-zero and 7-segment output.
module down_counter8
  import down_counter8_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  input  logic             iStart,
  input  logic             iPause,
  output logic [WIDTH-1:0] oQ,
  output logic             oDone,
  output logic             oBusy,
  output logic [6:0]       oDisplay
);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic             presc_clear, presc_en, tick_c;

  down_counter8_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK    (CLK),
    .rst    (rst),
    .clear  (presc_clear),
    .en     (presc_en),
    .tick_c (tick_c)
  );

  display7 u_display7 (
    .value (4'(oQ)),
    .seg   (oDisplay)
  );

  // State and registered outputs; done/busy follow the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= ST_IDLE;
      oQ    <= '0;
      oDone <= 1'b0;
      oBusy <= 1'b0;
    end else begin
      state <= state_n;
      oQ    <= q_n;
      oDone <= (state_n == ST_DONE);
      oBusy <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
    end
  end

  // Next-state logic; priority iLoad > iPause > iStart > tick.
  always_comb begin
    state_n     = state;
    q_n         = oQ;
    presc_clear = 1'b0;
    presc_en    = 1'b0;
    if (iLoad) begin
      q_n         = iData;
      state_n     = ST_IDLE;
      presc_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            if (oQ != '0) begin
              state_n     = ST_RUN;
              presc_clear = 1'b1;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (iPause) begin
            state_n = ST_PAUSE;
          end else begin
            presc_en = 1'b1;
            if (tick_c && (oQ != '0)) begin
              q_n = oQ - WIDTH'(1);
              if (oQ == WIDTH'(1)) state_n = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (iStart && !iPause) state_n = ST_RUN;
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter8.sv
// Directed bench for down_counter8: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_down_counter8;

  logic       clk = 1'b0;
  logic       rst, load, start, pause;
  logic [2:0] data;
  logic [2:0] q_a, q_b;
  logic       done_a, done_b, busy_a, busy_b;
  logic [6:0] disp_a, disp_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  down_counter8 #(.WIDTH(3), .TICK_DIV(1)) dut_a (
    .CLK(clk), .rst(rst), .iLoad(load), .iData(data), .iStart(start), .iPause(pause),
    .oQ(q_a), .oDone(done_a), .oBusy(busy_a), .oDisplay(disp_a)
  );

  down_counter8 #(.WIDTH(3), .TICK_DIV(4)) dut_b (
    .CLK(clk), .rst(rst), .iLoad(load), .iData(data), .iStart(start), .iPause(pause),
    .oQ(q_b), .oDone(done_b), .oBusy(busy_b), .oDisplay(disp_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; data = 3'd0;
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1; data = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #2;

    // 1. Reset dominates a simultaneous load
    rst = 1'b1; load = 1'b1; data = 3'd5;
    step(); step();
    check("rst_q", q_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_disp", disp_a, 7'h3F);
    check("rst_q_b", q_b, 0);
    idle_inputs();

    // 2. Full countdown, no wrap
    do_load(3'd5);
    check("ld5_q", q_a, 5);
    check("ld5_disp", disp_a, 7'h6D);
    check("ld5_busy", busy_a, 0);
    do_start();
    check("st_q", q_a, 5);
    check("st_busy", busy_a, 1);
    for (int v = 4; v >= 0; v--) begin
      step();
      check("cnt_q", q_a, v);
      check("cnt_done", done_a, (v == 0) ? 1 : 0);
    end
    check("end_busy", busy_a, 0);
    check("end_disp", disp_a, 7'h3F);
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      step();
      check("hold0_q", q_a, 0);
      check("hold0_done", done_a, 1);
    end
    start = 1'b0;

    // 3. Pause and resume
    do_load(3'd7);
    check("ld7_done", done_a, 0);
    do_start();
    step(); check("p_q6", q_a, 6);
    step(); check("p_q5", q_a, 5);
    pause = 1'b1;
    step();
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pause_q", q_a, 5);
      check("pause_busy", busy_a, 1);
      step();
    end
    check("pause_q_last", q_a, 5);
    do_start();
    check("res_q", q_a, 5);
    step(); check("res_q4", q_a, 4);
    step(); check("res_q3", q_a, 3);
    check("res_disp", disp_a, 7'h4F);

    // 4. Zero load goes straight to DONE
    do_load(3'd0);
    do_start();
    check("z_q", q_a, 0);
    check("z_done", done_a, 1);
    check("z_busy", busy_a, 0);

    // 5. Load beats pause and start while running
    do_load(3'd7);
    do_start();
    step(); step(); step();
    check("pr_pre_q", q_a, 4);
    load = 1'b1; data = 3'd3; pause = 1'b1; start = 1'b1;
    step();
    idle_inputs();
    check("pr_q", q_a, 3);
    check("pr_done", done_a, 0);
    check("pr_busy", busy_a, 0);
    step();
    check("pr_idle_q", q_a, 3);

    // 6. TICK_DIV=4 timing and mid-count reset
    do_load(3'd2);
    do_start();                                  // edge k
    step(); step(); step();                      // k+3
    check("d4_q_k3", q_b, 2);
    check("d4_busy", busy_b, 1);
    step();                                      // k+4
    check("d4_q_k4", q_b, 1);
    step(); step(); step();                      // k+7
    check("d4_q_k7", q_b, 1);
    check("d4_done_k7", done_b, 0);
    step();                                      // k+8
    check("d4_q_k8", q_b, 0);
    check("d4_done_k8", done_b, 1);

    do_load(3'd2);
    do_start();                                  // edge k
    for (int i = 0; i < 4; i++) step();          // k+4
    check("d4r_q_k4", q_b, 1);
    rst = 1'b1;
    step();                                      // k+5
    rst = 1'b0;
    check("d4r_q", q_b, 0);
    check("d4r_busy", busy_b, 0);
    check("d4r_done", done_b, 0);
    step(); step();
    check("d4r_hold_q", q_b, 0);
    check("d4r_hold_busy", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
